issue_stage: RTL and testbench
==============================

// Module: issue_stage
// PURPOSE
//   Decode-to-execute issue stage for the 16-entry general register file.
//   - Holds one decoded instruction in a slot and presents its register indices to the register file.
//   - Stalls while either indexed register is reserved.
//   - On issue, reserves the destination and launches registered operands to execute over a valid/ready handshake.
// PARAMETERS
//   W_OP   8   opcode width
//   W_RD   4   register index width (16 registers)
//   W_OPR  32  operand/data width
//   W_IMM  16  immediate width
// PORTS
//   clk          in   1      clock
//   reset        in   1      synchronous, active-low reset
//   in_valid_i   in   1      decoded instruction valid
//   in_ready_o   out  1      slot can accept this cycle
//   in_op_i      in   W_OP   opcode
//   in_r0_i      in   W_RD   destination and first source index
//   in_r1_i      in   W_RD   second source index
//   in_imm_i     in   W_IMM  immediate
//   in_wr_i      in   1      instruction writes in_r0_i
//   r0_o         out  W_RD   register file read index 0 (slot r0)
//   r1_o         out  W_RD   register file read index 1 (slot r1)
//   w_reserve_o  out  1      reserve r0_o at this edge
//   r_opr0_i     in   W_OPR  register file data for r0_o
//   r_opr1_i     in   W_OPR  register file data for r1_o
//   reserved_i   in   1      r0_o or r1_o currently reserved
//   flush_i      in   1      discard slot and execute output
//   ex_valid_o   out  1      execute output valid
//   ex_ready_i   in   1      execute accepts
//   ex_op_o      out  W_OP   opcode
//   ex_rd_o      out  W_RD   destination index
//   ex_opr0_o    out  W_OPR  operand 0
//   ex_opr1_o    out  W_OPR  operand 1
//   ex_imm_o     out  W_IMM  immediate
//   ex_wr_o      out  1      writeback required
// BEHAVIOUR
//   - State machine: EMPTY (no slot), HOLD (slot valid), STALL_DEP (reserved_i=1), STALL_EX (ex_valid_o & ~ex_ready_i).
//     STALL_DEP takes priority over STALL_EX when both apply.
//   - ex_free = ~ex_valid_o | ex_ready_i.
//   - issue = slot_v & ~reserved_i & ex_free & ~flush_i.
//   - w_reserve_o = issue & slot_wr. It is combinational, so a reservation is made only in the issuing cycle.
//   - in_ready_o = ~slot_v | issue (never during flush_i). Accept = in_valid_i & in_ready_o.
//     Issue and accept may occur in the same edge.
//   - On issue edge:
//     - Load ex_* from the slot: opr0 <- r_opr0_i, opr1 <- r_opr1_i, rd <- slot r0.
//     - Set ex_valid_o = 1.
//   - ex_valid_o clears on ex_ready_i without issue. ex_* hold stable while ex_valid_o & ~ex_ready_i.
//   - Latency: accept edge E0; issue at earliest E1; ex_valid_o high the cycle after E1.
//     Zero-stall throughput is 1 instruction/cycle.
//   - Writeback to a reserved register clears the reservation only at the clock edge.
//     The slot therefore stays stalled in the writeback cycle and issues on the following cycle. There is no bypass.
//   - Reserved r0 with in_wr_i=1 stalls (WAW). A read of reserved r1 stalls (RAW).
//   - flush_i: slot_v <- 0 and ex_valid_o <- 0 at the edge.
//     - Beats issue and accept.
//     - No w_reserve_o in the flush cycle.
//     - Reservations issued earlier remain owned by the register file.
//   - Reset (reset=0 at edge), also mid-stall:
//     - slot_v = 0, state = EMPTY, ex_valid_o = 0.
//     - ex_op_o/ex_rd_o/ex_opr*/ex_imm_o/ex_wr_o = 0.
//     - r0_o = r1_o = 0.
//     - in_ready_o and w_reserve_o low while reset=0.
// CONFIGURATION
//   ISSUE_STALL_CNT_EN defined:
//   - Adds outputs stall_dep_cnt_o [31:0] and stall_ex_cnt_o [31:0].
//   - Each increments once per cycle spent in STALL_DEP or STALL_EX respectively.
//   - Both saturate at 32'hFFFFFFFF and are cleared by reset.
//   Undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//   - Reset: hold reset=0 for 2 cycles with in_valid_i=1 -> in_ready_o=0, ex_valid_o=0, w_reserve_o=0, all ex_* zero.
//   - Back-to-back: 3 instructions, reserved_i=0, ex_ready_i=1 -> ex_valid_o high 3 consecutive cycles starting 2 cycles after the first accept.
//     Expected operands for r0=3,r1=5: ex_opr0_o=r_opr0_i(reg3), ex_opr1_o=r_opr1_i(reg5).
//     w_reserve_o pulses once per in_wr_i=1 instruction.
//   - RAW stall: slot with r1=7, reserved_i=1 for 4 cycles -> no issue, in_ready_o=0, w_reserve_o=0.
//     Release reserved_i -> issue next edge with ex_opr1_o = 32'hDEADBEEF written to reg7.
//   - Execute backpressure: ex_ready_i=0 for 3 cycles with two queued instructions -> ex_* stable.
//     Second instruction held in slot; no reservation until ex_ready_i=1.
//   - Flush during STALL_DEP with in_valid_i=1 -> slot and ex_valid_o cleared next edge, new instruction not accepted, w_reserve_o=0.
//   - With ISSUE_STALL_CNT_EN: 5 dependency-stall cycles then 2 execute-stall cycles -> stall_dep_cnt_o=5, stall_ex_cnt_o=2.

Source files
------------

// File: rtl/issue_stage_if.sv
// Execute-side bus of the issue stage.
//   master : drives ex_valid, ex_op, ex_rd, ex_opr0, ex_opr1, ex_imm, ex_wr
//            and receives ex_ready (the issue stage uses this side)
//   slave  : the mirror view, used by the execute unit
// Parameters follow the issue stage: W_OP opcode, W_RD register index,
// W_OPR operand width, W_IMM immediate width.
interface issue_stage_if #(
  parameter int W_OP  = 8,
  parameter int W_RD  = 4,
  parameter int W_OPR = 32,
  parameter int W_IMM = 16
);
  logic             ex_valid;
  logic             ex_ready;
  logic [W_OP-1:0]  ex_op;
  logic [W_RD-1:0]  ex_rd;
  logic [W_OPR-1:0] ex_opr0;
  logic [W_OPR-1:0] ex_opr1;
  logic [W_IMM-1:0] ex_imm;
  logic             ex_wr;

  modport master (
    output ex_valid, ex_op, ex_rd, ex_opr0, ex_opr1, ex_imm, ex_wr,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_op, ex_rd, ex_opr0, ex_opr1, ex_imm, ex_wr,
    output ex_ready
  );
endinterface

// File: rtl/issue_stage.sv
// Decode-to-execute issue stage for a 16-entry register file.
// Holds one decoded instruction, presents its register indices to the
// register file, stalls while either indexed register is reserved, and on
// issue reserves the destination and launches registered operands to execute.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   in_valid_i/ready_o  decode handshake; in_op_i, in_r0_i, in_r1_i,
//                       in_imm_i, in_wr_i carry the decoded instruction
//   r0_o, r1_o          register file read indices (slot r0 / r1)
//   w_reserve_o         reserve r0_o at this edge (issuing cycle only)
//   r_opr0_i, r_opr1_i  register file data for r0_o / r1_o
//   reserved_i          r0_o or r1_o currently reserved
//   flush_i             discard slot and execute output
//   ex                  execute bus (issue_stage_if.master)
//
// Optional feature: define ISSUE_STALL_CNT_EN to add stall_dep_cnt_o and
// stall_ex_cnt_o, saturating counts of cycles spent in STALL_DEP / STALL_EX.
module issue_stage #(
  parameter int W_OP  = 8,
  parameter int W_RD  = 4,
  parameter int W_OPR = 32,
  parameter int W_IMM = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W_OP-1:0]  in_op_i,
  input  logic [W_RD-1:0]  in_r0_i,
  input  logic [W_RD-1:0]  in_r1_i,
  input  logic [W_IMM-1:0] in_imm_i,
  input  logic             in_wr_i,
  output logic [W_RD-1:0]  r0_o,
  output logic [W_RD-1:0]  r1_o,
  output logic             w_reserve_o,
  input  logic [W_OPR-1:0] r_opr0_i,
  input  logic [W_OPR-1:0] r_opr1_i,
  input  logic             reserved_i,
  input  logic             flush_i,
  issue_stage_if.master    ex
`ifdef ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]      stall_dep_cnt_o,
  output logic [31:0]      stall_ex_cnt_o
`endif
);

  localparam logic [1:0] EMPTY     = 2'd0;
  localparam logic [1:0] HOLD      = 2'd1;
  localparam logic [1:0] STALL_DEP = 2'd2;
  localparam logic [1:0] STALL_EX  = 2'd3;

  logic             slotV_q,   slotV_d;
  logic [W_OP-1:0]  slotOp_q,  slotOp_d;
  logic [W_RD-1:0]  slotR0_q,  slotR0_d;
  logic [W_RD-1:0]  slotR1_q,  slotR1_d;
  logic [W_IMM-1:0] slotImm_q, slotImm_d;
  logic             slotWr_q,  slotWr_d;

  logic             exValid_q, exValid_d;
  logic [W_OP-1:0]  exOp_q,    exOp_d;
  logic [W_RD-1:0]  exRd_q,    exRd_d;
  logic [W_OPR-1:0] exOpr0_q,  exOpr0_d;
  logic [W_OPR-1:0] exOpr1_q,  exOpr1_d;
  logic [W_IMM-1:0] exImm_q,   exImm_d;
  logic             exWr_q,    exWr_d;

  logic [1:0] curState;
  logic       exFree;
  logic       issue;
  logic       accept;

  // The state is a pure function of slot occupancy and this cycle's hazards;
  // a dependency stall outranks an execute stall.
  always_comb begin
    exFree = ~exValid_q | ex.ex_ready;
    if (!slotV_q)         curState = EMPTY;
    else if (reserved_i)  curState = STALL_DEP;
    else if (!exFree)     curState = STALL_EX;
    else                  curState = HOLD;
  end

  // Flush and reset both suppress issue, acceptance and the reservation pulse.
  assign issue       = (curState == HOLD) & ~flush_i & reset;
  assign in_ready_o  = (~slotV_q | issue) & ~flush_i & reset;
  assign accept      = in_valid_i & in_ready_o;
  assign w_reserve_o = issue & slotWr_q;

  assign r0_o        = slotR0_q;
  assign r1_o        = slotR1_q;
  assign ex.ex_valid = exValid_q;
  assign ex.ex_op    = exOp_q;
  assign ex.ex_rd    = exRd_q;
  assign ex.ex_opr0  = exOpr0_q;
  assign ex.ex_opr1  = exOpr1_q;
  assign ex.ex_imm   = exImm_q;
  assign ex.ex_wr    = exWr_q;

  // Next-state for slot and execute registers. Accept and issue can share an
  // edge: the slot refills while its previous contents move to execute.
  always_comb begin
    slotV_d   = slotV_q;
    slotOp_d  = slotOp_q;
    slotR0_d  = slotR0_q;
    slotR1_d  = slotR1_q;
    slotImm_d = slotImm_q;
    slotWr_d  = slotWr_q;
    exValid_d = exValid_q;
    exOp_d    = exOp_q;
    exRd_d    = exRd_q;
    exOpr0_d  = exOpr0_q;
    exOpr1_d  = exOpr1_q;
    exImm_d   = exImm_q;
    exWr_d    = exWr_q;
    if (flush_i) begin
      slotV_d   = 1'b0;
      exValid_d = 1'b0;
    end else begin
      if (accept) begin
        slotV_d   = 1'b1;
        slotOp_d  = in_op_i;
        slotR0_d  = in_r0_i;
        slotR1_d  = in_r1_i;
        slotImm_d = in_imm_i;
        slotWr_d  = in_wr_i;
      end else if (issue) begin
        slotV_d = 1'b0;
      end
      if (issue) begin
        exValid_d = 1'b1;
        exOp_d    = slotOp_q;
        exRd_d    = slotR0_q;
        exOpr0_d  = r_opr0_i;
        exOpr1_d  = r_opr1_i;
        exImm_d   = slotImm_q;
        exWr_d    = slotWr_q;
      end else if (ex.ex_ready) begin
        exValid_d = 1'b0;
      end
    end
  end

  // State registers; reset clears everything, including the payload fields.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slotV_q   <= 1'b0;
      slotOp_q  <= '0;
      slotR0_q  <= '0;
      slotR1_q  <= '0;
      slotImm_q <= '0;
      slotWr_q  <= 1'b0;
      exValid_q <= 1'b0;
      exOp_q    <= '0;
      exRd_q    <= '0;
      exOpr0_q  <= '0;
      exOpr1_q  <= '0;
      exImm_q   <= '0;
      exWr_q    <= 1'b0;
    end else begin
      slotV_q   <= slotV_d;
      slotOp_q  <= slotOp_d;
      slotR0_q  <= slotR0_d;
      slotR1_q  <= slotR1_d;
      slotImm_q <= slotImm_d;
      slotWr_q  <= slotWr_d;
      exValid_q <= exValid_d;
      exOp_q    <= exOp_d;
      exRd_q    <= exRd_d;
      exOpr0_q  <= exOpr0_d;
      exOpr1_q  <= exOpr1_d;
      exImm_q   <= exImm_d;
      exWr_q    <= exWr_d;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] depCnt_q;
  logic [31:0] exCnt_q;

  // Saturating stall counters, one increment per stalled cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      depCnt_q <= '0;
      exCnt_q  <= '0;
    end else begin
      if (curState == STALL_DEP && depCnt_q != 32'hFFFF_FFFF)
        depCnt_q <= depCnt_q + 32'd1;
      if (curState == STALL_EX && exCnt_q != 32'hFFFF_FFFF)
        exCnt_q <= exCnt_q + 32'd1;
    end
  end

  assign stall_dep_cnt_o = depCnt_q;
  assign stall_ex_cnt_o  = exCnt_q;
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed scenarios with fixed
// expectations plus a randomized run checked by an in-order scoreboard.
module tb_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  in_op_i;
  logic [3:0]  in_r0_i;
  logic [3:0]  in_r1_i;
  logic [15:0] in_imm_i;
  logic        in_wr_i;
  logic [3:0]  r0_o;
  logic [3:0]  r1_o;
  logic        w_reserve_o;
  logic [31:0] r_opr0_i;
  logic [31:0] r_opr1_i;
  logic        reserved_i;
  logic        flush_i;
`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_dep_cnt_o;
  logic [31:0] stall_ex_cnt_o;
`endif

  logic [31:0] regs [16];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  r0;
    logic [3:0]  r1;
    logic [15:0] imm;
    logic        wr;
  } instT;

  issue_stage_if exIf ();

  issue_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_op_i     (in_op_i),
    .in_r0_i     (in_r0_i),
    .in_r1_i     (in_r1_i),
    .in_imm_i    (in_imm_i),
    .in_wr_i     (in_wr_i),
    .r0_o        (r0_o),
    .r1_o        (r1_o),
    .w_reserve_o (w_reserve_o),
    .r_opr0_i    (r_opr0_i),
    .r_opr1_i    (r_opr1_i),
    .reserved_i  (reserved_i),
    .flush_i     (flush_i),
    .ex          (exIf)
`ifdef ISSUE_STALL_CNT_EN
    ,
    .stall_dep_cnt_o (stall_dep_cnt_o),
    .stall_ex_cnt_o  (stall_ex_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Register file read ports seen by the stage.
  assign r_opr0_i = regs[r0_o];
  assign r_opr1_i = regs[r1_o];

  task automatic applyStimulus(input logic v, input logic [7:0] op, input logic [3:0] r0,
                               input logic [3:0] r1, input logic [15:0] imm, input logic wr);
    in_valid_i = v;
    in_op_i    = op;
    in_r0_i    = r0;
    in_r1_i    = r1;
    in_imm_i   = imm;
    in_wr_i    = wr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    reserved_i = 1'b0;
    flush_i    = 1'b0;
    exIf.ex_ready = 1'b1;
    applyStimulus(1'b1, 8'hA5, 4'd3, 4'd5, 16'h1234, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (in_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready_o); end
      total++;
      if (exIf.ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_ex_valid: got %b want 0", exIf.ex_valid); end
      total++;
      if (w_reserve_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_w_reserve: got %b want 0", w_reserve_o); end
      total++;
      if ({exIf.ex_op, exIf.ex_rd, exIf.ex_opr0, exIf.ex_opr1, exIf.ex_imm, exIf.ex_wr} !== 93'd0) begin
        bad++;
        $display("[TB] FAIL reset_ex_fields: got op=%h rd=%h o0=%h o1=%h imm=%h wr=%b want all zero",
                 exIf.ex_op, exIf.ex_rd, exIf.ex_opr0, exIf.ex_opr1, exIf.ex_imm, exIf.ex_wr);
      end
      total++;
      if ({r0_o, r1_o} !== 8'd0) begin bad++; $display("[TB] FAIL reset_rf_index: got %h want 00", {r0_o, r1_o}); end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ops [3] = '{8'h11, 8'h22, 8'h33};
    logic [3:0]  r0s [3] = '{4'd3, 4'd1, 4'd4};
    logic [3:0]  r1s [3] = '{4'd5, 4'd2, 4'd6};
    logic [15:0] imms[3] = '{16'h0101, 16'h0202, 16'h0303};
    logic        wrs [3] = '{1'b1, 1'b0, 1'b1};
    logic [5:0]  expV;
    logic [5:0]  expRes;
    int k;
    expV   = 6'b011100;
    expRes = 6'b001010;
    reserved_i    = 1'b0;
    exIf.ex_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) applyStimulus(1'b1, ops[c], r0s[c], r1s[c], imms[c], wrs[c]);
      else       applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 16'h0000, 1'b0);
      @(negedge clk);
      total++;
      if (exIf.ex_valid !== expV[c]) begin bad++; $display("[TB] FAIL b2b_ex_valid c%0d: got %b want %b", c, exIf.ex_valid, expV[c]); end
      total++;
      if (w_reserve_o !== expRes[c]) begin bad++; $display("[TB] FAIL b2b_w_reserve c%0d: got %b want %b", c, w_reserve_o, expRes[c]); end
      total++;
      if (in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_in_ready c%0d: got %b want 1", c, in_ready_o); end
      if (c >= 2 && c <= 4) begin
        k = c - 2;
        total++;
        if ({exIf.ex_op, exIf.ex_rd, exIf.ex_opr0, exIf.ex_opr1, exIf.ex_imm, exIf.ex_wr} !==
            {ops[k], r0s[k], regs[r0s[k]], regs[r1s[k]], imms[k], wrs[k]}) begin
          bad++;
          $display("[TB] FAIL b2b_ex_fields c%0d: got op=%h rd=%h o0=%h o1=%h imm=%h wr=%b want op=%h rd=%h o0=%h o1=%h imm=%h wr=%b",
                   c, exIf.ex_op, exIf.ex_rd, exIf.ex_opr0, exIf.ex_opr1, exIf.ex_imm, exIf.ex_wr,
                   ops[k], r0s[k], regs[r0s[k]], regs[r1s[k]], imms[k], wrs[k]);
        end
      end
      nextCycle();
    end
  endtask

  task automatic test_raw_stall();
    reserved_i    = 1'b0;
    exIf.ex_ready = 1'b1;
    applyStimulus(1'b1, 8'h44, 4'd2, 4'd7, 16'h4444, 1'b1);
    @(negedge clk);
    total++;
    if (in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL raw_accept_ready: got %b want 1", in_ready_o); end
    nextCycle();
    applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 16'h0000, 1'b0);
    reserved_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if ({in_ready_o, w_reserve_o} !== 2'b00) begin
        bad++; $display("[TB] FAIL raw_stall c%0d: got ready=%b reserve=%b want 0 0", c, in_ready_o, w_reserve_o);
      end
      if (c >= 2) begin
        total++;
        if (exIf.ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL raw_no_issue c%0d: got %b want 0", c, exIf.ex_valid); end
      end
      nextCycle();
    end
    regs[7]    = 32'hDEADBEEF;
    reserved_i = 1'b0;
    @(negedge clk);
    total++;
    if ({w_reserve_o, in_ready_o} !== 2'b11) begin
      bad++; $display("[TB] FAIL raw_release: got reserve=%b ready=%b want 1 1", w_reserve_o, in_ready_o);
    end
    nextCycle();
    @(negedge clk);
    total++;
    if ({exIf.ex_valid, exIf.ex_rd, exIf.ex_opr0, exIf.ex_opr1} !== {1'b1, 4'd2, regs[2], 32'hDEADBEEF}) begin
      bad++;
      $display("[TB] FAIL raw_issue: got v=%b rd=%h o0=%h o1=%h want v=1 rd=2 o0=%h o1=deadbeef",
               exIf.ex_valid, exIf.ex_rd, exIf.ex_opr0, exIf.ex_opr1, regs[2]);
    end
    nextCycle();
    @(negedge clk);
    total++;
    if (exIf.ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL raw_drain: got %b want 0", exIf.ex_valid); end
    nextCycle();
  endtask

  task automatic test_backpressure();
    reserved_i    = 1'b0;
    exIf.ex_ready = 1'b0;
    applyStimulus(1'b1, 8'h55, 4'd8, 4'd9, 16'h5555, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 8'h66, 4'd10, 4'd11, 16'h6666, 1'b1);
    @(negedge clk);
    total++;
    if ({w_reserve_o, in_ready_o} !== 2'b11) begin
      bad++; $display("[TB] FAIL bp_first_issue: got reserve=%b ready=%b want 1 1", w_reserve_o, in_ready_o);
    end
    nextCycle();
    applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 16'h0000, 1'b0);
    for (int c = 2; c <= 5; c++) begin
      if (c == 5) exIf.ex_ready = 1'b1;
      @(negedge clk);
      total++;
      if ({exIf.ex_valid, exIf.ex_op, exIf.ex_rd, exIf.ex_opr0, exIf.ex_opr1, exIf.ex_imm, exIf.ex_wr} !==
          {1'b1, 8'h55, 4'd8, regs[8], regs[9], 16'h5555, 1'b1}) begin
        bad++;
        $display("[TB] FAIL bp_hold c%0d: got v=%b op=%h rd=%h o0=%h o1=%h want v=1 op=55 rd=8 o0=%h o1=%h",
                 c, exIf.ex_valid, exIf.ex_op, exIf.ex_rd, exIf.ex_opr0, exIf.ex_opr1, regs[8], regs[9]);
      end
      total++;
      if (w_reserve_o !== (c == 5)) begin
        bad++; $display("[TB] FAIL bp_reserve c%0d: got %b want %b", c, w_reserve_o, (c == 5));
      end
      nextCycle();
    end
    @(negedge clk);
    total++;
    if ({exIf.ex_valid, exIf.ex_op, exIf.ex_rd, exIf.ex_opr0} !== {1'b1, 8'h66, 4'd10, regs[10]}) begin
      bad++;
      $display("[TB] FAIL bp_second: got v=%b op=%h rd=%h o0=%h want v=1 op=66 rd=a o0=%h",
               exIf.ex_valid, exIf.ex_op, exIf.ex_rd, exIf.ex_opr0, regs[10]);
    end
    nextCycle();
    @(negedge clk);
    total++;
    if (exIf.ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain: got %b want 0", exIf.ex_valid); end
    nextCycle();
  endtask

  task automatic test_flush();
    reserved_i    = 1'b0;
    exIf.ex_ready = 1'b0;
    applyStimulus(1'b1, 8'h77, 4'd12, 4'd13, 16'h7777, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 8'h88, 4'd14, 4'd15, 16'h8888, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 16'h0000, 1'b0);
    reserved_i = 1'b1;
    @(negedge clk);
    total++;
    if ({exIf.ex_valid, in_ready_o, w_reserve_o} !== 3'b100) begin
      bad++; $display("[TB] FAIL flush_pre: got v=%b ready=%b reserve=%b want 1 0 0", exIf.ex_valid, in_ready_o, w_reserve_o);
    end
    nextCycle();
    flush_i = 1'b1;
    applyStimulus(1'b1, 8'h99, 4'd1, 4'd1, 16'h9999, 1'b1);
    @(negedge clk);
    total++;
    if ({in_ready_o, w_reserve_o} !== 2'b00) begin
      bad++; $display("[TB] FAIL flush_dep_cycle: got ready=%b reserve=%b want 0 0", in_ready_o, w_reserve_o);
    end
    nextCycle();
    flush_i       = 1'b0;
    reserved_i    = 1'b0;
    exIf.ex_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 16'h0000, 1'b0);
    @(negedge clk);
    total++;
    if ({exIf.ex_valid, in_ready_o, w_reserve_o} !== 3'b010) begin
      bad++; $display("[TB] FAIL flush_dep_after: got v=%b ready=%b reserve=%b want 0 1 0", exIf.ex_valid, in_ready_o, w_reserve_o);
    end
    nextCycle();
    // Second flush lands on a slot that would otherwise issue this cycle.
    applyStimulus(1'b1, 8'hAA, 4'd5, 4'd6, 16'hAAAA, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 16'h0000, 1'b0);
    flush_i = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready_o, w_reserve_o} !== 2'b00) begin
      bad++; $display("[TB] FAIL flush_issue_cycle: got ready=%b reserve=%b want 0 0", in_ready_o, w_reserve_o);
    end
    nextCycle();
    flush_i = 1'b0;
    @(negedge clk);
    total++;
    if ({exIf.ex_valid, in_ready_o} !== 2'b01) begin
      bad++; $display("[TB] FAIL flush_issue_after: got v=%b ready=%b want 0 1", exIf.ex_valid, in_ready_o);
    end
    nextCycle();
  endtask

`ifdef ISSUE_STALL_CNT_EN
  task automatic test_stall_cnt();
    reset = 1'b0;
    nextCycle();
    reset         = 1'b1;
    reserved_i    = 1'b0;
    exIf.ex_ready = 1'b0;
    applyStimulus(1'b1, 8'hC1, 4'd1, 4'd2, 16'h00C1, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 8'hC2, 4'd3, 4'd4, 16'h00C2, 1'b1);
    @(negedge clk);
    total++;
    if ({stall_dep_cnt_o, stall_ex_cnt_o} !== 64'd0) begin
      bad++; $display("[TB] FAIL cnt_clear: got dep=%0d ex=%0d want 0 0", stall_dep_cnt_o, stall_ex_cnt_o);
    end
    nextCycle();
    applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 16'h0000, 1'b0);
    for (int c = 0; c < 7; c++) begin
      reserved_i = (c < 5);
      nextCycle();
    end
    reserved_i    = 1'b0;
    exIf.ex_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({stall_dep_cnt_o, stall_ex_cnt_o} !== {32'd5, 32'd2}) begin
      bad++; $display("[TB] FAIL cnt_values: got dep=%0d ex=%0d want 5 2", stall_dep_cnt_o, stall_ex_cnt_o);
    end
    nextCycle();
    nextCycle();
    nextCycle();
  endtask
`endif

  task automatic test_random();
    instT q[$];
    instT t;
    instT e;
    int resCount = 0;
    int wrCount  = 0;
    flush_i = 1'b0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom), 4'($urandom),
                      16'($urandom), 1'($urandom_range(0, 1)));
        reserved_i    = ($urandom_range(0, 9) < 3);
        exIf.ex_ready = ($urandom_range(0, 9) < 7);
      end else begin
        applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 16'h0000, 1'b0);
        reserved_i    = 1'b0;
        exIf.ex_ready = 1'b1;
      end
      @(negedge clk);
      if (w_reserve_o) begin
        resCount++;
        total++;
        if (reserved_i !== 1'b0) begin bad++; $display("[TB] FAIL rnd_reserve_while_reserved c%0d", c); end
      end
      if (exIf.ex_valid && exIf.ex_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("[TB] FAIL rnd_spurious c%0d: got op=%h with nothing outstanding want none", c, exIf.ex_op);
        end else begin
          e = q.pop_front();
          if ({exIf.ex_op, exIf.ex_rd, exIf.ex_opr0, exIf.ex_opr1, exIf.ex_imm, exIf.ex_wr} !==
              {e.op, e.r0, regs[e.r0], regs[e.r1], e.imm, e.wr}) begin
            bad++;
            $display("[TB] FAIL rnd_ex c%0d: got op=%h rd=%h o0=%h o1=%h imm=%h wr=%b want op=%h rd=%h o0=%h o1=%h imm=%h wr=%b",
                     c, exIf.ex_op, exIf.ex_rd, exIf.ex_opr0, exIf.ex_opr1, exIf.ex_imm, exIf.ex_wr,
                     e.op, e.r0, regs[e.r0], regs[e.r1], e.imm, e.wr);
          end
        end
      end
      if (in_valid_i && in_ready_o) begin
        t.op = in_op_i; t.r0 = in_r0_i; t.r1 = in_r1_i; t.imm = in_imm_i; t.wr = in_wr_i;
        q.push_back(t);
        if (in_wr_i) wrCount++;
      end
      nextCycle();
    end
    total++;
    if (q.size() != 0) begin bad++; $display("[TB] FAIL rnd_drain: got %0d outstanding want 0", q.size()); end
    total++;
    if (resCount != wrCount) begin bad++; $display("[TB] FAIL rnd_reserve_count: got %0d want %0d", resCount, wrCount); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    test_reset();
    test_back_to_back();
    test_raw_stall();
    test_backpressure();
    test_flush();
`ifdef ISSUE_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
